// File: rtl/audio_mix_sequencer.sv
// audio_mix_sequencer: time-multiplexed stereo mixer. A single shared adder
// accumulates one source channel per clock into left/right sums, then
// publishes saturated unsigned samples for the sigma-delta DACs.
module audio_mix_sequencer #(
   parameter int unsigned NCH  = 8,
   parameter int unsigned OUTW = 10
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                sample_tick,
   input  logic [NCH*8-1:0]    ch_data,
   input  logic [NCH*2-1:0]    ch_pan,
   input  logic [NCH*2-1:0]    ch_atten,
   input  logic                mute,
   output logic                busy,
   output logic                overrun,
   output logic [OUTW-1:0]     left_out,
   output logic [OUTW-1:0]     right_out,
   output logic                out_valid
);

   localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned AW = 8 + $clog2(NCH);
   localparam int unsigned CW = (AW > OUTW) ? AW : OUTW;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   state_t             state_q;
   logic [NCH*8-1:0]   data_q;
   logic [NCH*2-1:0]   pan_q;
   logic [NCH*2-1:0]   atten_q;
   logic               mute_q;
   logic [AW-1:0]      accl_q, accr_q;
   logic [AW-1:0]      accl_d, accr_d;
   logic [IW-1:0]      idx_q, idx_d;

   logic [7:0]         sel_data;
   logic [1:0]         sel_atten;
   logic [1:0]         sel_pan;
   logic [AW-1:0]      term;
   logic               last_ch;

   // Clamp an accumulator to the largest value representable on the output.
   function automatic logic [OUTW-1:0] sat(input logic [AW-1:0] a);
      logic [CW-1:0] ax;
      logic [CW-1:0] maxv;
      ax   = CW'(a);
      maxv = CW'({OUTW{1'b1}});
      return (ax > maxv) ? {OUTW{1'b1}} : OUTW'(ax);
   endfunction

   // Select the current channel from the shadow snapshot and form next sums.
   always_comb begin
      sel_data  = data_q[32'(idx_q) * 8 +: 8];
      sel_atten = atten_q[32'(idx_q) * 2 +: 2];
      sel_pan   = pan_q[32'(idx_q) * 2 +: 2];
      term      = AW'(sel_data >> sel_atten);
      accl_d    = accl_q + (sel_pan[0] ? term : '0);
      accr_d    = accr_q + (sel_pan[1] ? term : '0);
      idx_d     = idx_q + IW'(1);
      last_ch   = (idx_q == IW'(NCH - 1));
   end

   // Sequencer FSM with snapshot, accumulation and registered publish.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         data_q    <= '0;
         pan_q     <= '0;
         atten_q   <= '0;
         mute_q    <= 1'b0;
         accl_q    <= '0;
         accr_q    <= '0;
         idx_q     <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         out_valid <= 1'b0;
         left_out  <= '0;
         right_out <= '0;
      end else begin
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sample_tick) begin
                  data_q  <= ch_data;
                  pan_q   <= ch_pan;
                  atten_q <= ch_atten;
                  mute_q  <= mute;
                  accl_q  <= '0;
                  accr_q  <= '0;
                  idx_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               overrun <= sample_tick;
               accl_q  <= accl_d;
               accr_q  <= accr_d;
               idx_q   <= idx_d;
               if (last_ch) begin
                  state_q <= PUBLISH;
               end
            end
            PUBLISH: begin
               overrun   <= sample_tick;
               left_out  <= mute_q ? '0 : sat(accl_q);
               right_out <= mute_q ? '0 : sat(accr_q);
               out_valid <= 1'b1;
               busy      <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
